stream_demux: RTL and testbench

Parametrised 1-to-NCH stream demultiplexer with a valid/ready handshake and per-channel output registers. It is the registered, flow-controlled successor of the combinational 1-to-4 demux. Each packet's select is sampled on its first beat and held until the `last` beat, so multi-beat packets never split across channels. It sits between a single producer and NCH independent consumers.

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_chreg.sv | 47 ++++
 rtl/stream_demux.sv | 132 +++++++++++++
 tb/tb_stream_demux.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package stream_demux_pkg;

    localparam int STATE_W = 2;

    // IDLE  : waiting for the first beat of a packet
    // ROUTE : locked onto cur_sel until the last beat is accepted
    // DROP  : swallowing a packet whose first beat carried an unused select
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_demux_chreg.sv
// Single-entry output register (data, last, valid) for one demux channel.
// Latency: 1 cycle, beat accepted at edge k is presented from cycle k+1.
// Backpressure: in_ready = empty || out_ready, so full throughput while drained.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_data/in_last/in_valid    beat offered by the demux core
//   in_ready                    register can take a beat this cycle
//   out_data/out_last/out_valid registered beat towards the consumer
//   out_ready                   consumer takes the beat this cycle
module stream_demux_chreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    logic load;

    // Loading into a register that drains in the same cycle keeps one
    // beat per cycle flowing without a second storage slot.
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= in_last;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-NCH packet demux: select sampled on first beat, held until last beat.
// Latency: 1 cycle through a per-channel output register.
// Backpressure: s_ready follows the target channel's register; drops always ready.
//
// Ports:
//   clk, rst_n        clock, async active-low reset (s_ready held low in reset)
//   s_data/s_sel/s_last/s_valid/s_ready   single input stream
//   m_data/m_last/m_valid/m_ready         NCH output streams, channel i at
//                                         m_data[i*DATA_W +: DATA_W]
//   err_cnt           saturating count of dropped packets, present only when
//                     STREAM_DEMUX_ERRCNT_EN is defined
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NCH    = 4,
    parameter  int ERR_W  = 8,
    localparam int SEL_W  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [SEL_W-1:0]      s_sel,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [NCH*DATA_W-1:0] m_data,
    output logic [NCH-1:0]        m_last,
    output logic [NCH-1:0]        m_valid,
    input  logic [NCH-1:0]        m_ready
`ifdef STREAM_DEMUX_ERRCNT_EN
    ,
    output logic [ERR_W-1:0]      err_cnt
`endif
);

    // One extra bit so the comparison also works when NCH is a power of two.
    localparam logic [SEL_W:0] NCH_CMP = (SEL_W+1)'(NCH);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] cur_sel, cur_sel_nxt;
    logic [SEL_W-1:0] tgt;
    logic [NCH-1:0]   tgt_oh;
    logic [NCH-1:0]   ch_in_vld;
    logic [NCH-1:0]   ch_in_rdy;
    logic             sel_ok;
    logic             fwd;
    logic             acc;

    // NCH below two has no meaning for a demux; an empty named scope makes a
    // bad configuration visible in the elaborated hierarchy.
    if (NCH < 2 || ERR_W < 1) begin : g_cfg_invalid
    end

    // Target decode: the live select only matters on a packet's first beat.
    always_comb begin
        sel_ok = ({1'b0, s_sel} < NCH_CMP);
        tgt    = (state == ROUTE) ? cur_sel : s_sel;
        fwd    = (state == ROUTE) || ((state == IDLE) && sel_ok);
        tgt_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            tgt_oh[i] = (tgt == SEL_W'(i));
        end
    end

    // Dropped beats never wait for a channel; forwarded beats wait only for
    // their own target, so a stalled channel cannot block other packets.
    assign s_ready   = rst_n && (fwd ? |(tgt_oh & ch_in_rdy) : 1'b1);
    assign acc       = s_valid && s_ready;
    assign ch_in_vld = {NCH{s_valid && fwd}} & tgt_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_sel <= '0;
        end else begin
            state   <= state_nxt;
            cur_sel <= cur_sel_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cur_sel_nxt = cur_sel;
        case (state)
            IDLE: begin
                if (acc) begin
                    cur_sel_nxt = s_sel;
                    // A single-beat packet leaves the FSM in IDLE.
                    if (!s_last) begin
                        state_nxt = sel_ok ? ROUTE : DROP;
                    end
                end
            end
            ROUTE, DROP: begin
                if (acc && s_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef STREAM_DEMUX_ERRCNT_EN
    // Counts packets, not beats: only the first beat of a dropped packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (acc && (state == IDLE) && !sel_ok && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        stream_demux_chreg #(
            .DATA_W (DATA_W)
        ) u_chreg (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (s_data),
            .in_last   (s_last),
            .in_valid  (ch_in_vld[i]),
            .in_ready  (ch_in_rdy[i]),
            .out_data  (m_data[i*DATA_W +: DATA_W]),
            .out_last  (m_last[i]),
            .out_valid (m_valid[i]),
            .out_ready (m_ready[i])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel instance fed through a scoreboard and a
// 3-channel instance (ERR_W=2) exercising unused select codes and err_cnt.
module tb_stream_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [7:0]  s_data;
    logic [1:0]  s_sel;
    logic        s_last, s_valid, s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_last, m_valid, m_ready;

    logic [7:0]  t_data;
    logic [1:0]  t_sel;
    logic        t_last, t_valid, t_ready;
    logic [23:0] tm_data;
    logic [2:0]  tm_last, tm_valid, tm_ready;

`ifdef STREAM_DEMUX_ERRCNT_EN
    logic [7:0]  err_cnt;
    logic [1:0]  t_err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected {last, data} per channel of the 4-channel instance.
    logic [8:0] q [4][$];

    stream_demux #(.DATA_W(8), .NCH(4), .ERR_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_sel   (s_sel),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef STREAM_DEMUX_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    stream_demux #(.DATA_W(8), .NCH(3), .ERR_W(2)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (t_data),
        .s_sel   (t_sel),
        .s_last  (t_last),
        .s_valid (t_valid),
        .s_ready (t_ready),
        .m_data  (tm_data),
        .m_last  (tm_last),
        .m_valid (tm_valid),
        .m_ready (tm_ready)
`ifdef STREAM_DEMUX_ERRCNT_EN
        ,
        .err_cnt (t_err_cnt)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer one beat to the 4-channel instance, wait (bounded) for s_ready,
    // record the expected output on channel ch and check one-cycle latency.
    task automatic send(input logic [7:0] d, input logic [1:0] sel, input logic last, input int ch);
        int n = 0;
        s_data  = d;
        s_sel   = sel;
        s_last  = last;
        s_valid = 1'b1;
        #1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: beat %0h got s_ready=0, expected 1 within 50 cycles", d);
        end else begin
            q[ch].push_back({last, d});
            @(posedge clk);
            #1;
            chk($sformatf("latency_ch%0d_%0h", ch, d), 64'(m_valid[ch]), 64'd1);
            chk($sformatf("only_ch%0d_%0h", ch, d), 64'(m_valid & m_ready & ~(4'b1 << ch)), 64'd0);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Offer one beat to the 3-channel instance (all consumers ready).
    task automatic send3(input logic [7:0] d, input logic [1:0] sel, input logic last,
                         input logic [2:0] exp_vld);
        t_data  = d;
        t_sel   = sel;
        t_last  = last;
        t_valid = 1'b1;
        #1;
        chk($sformatf("dut3_s_ready_%0h", d), 64'(t_ready), 64'd1);
        @(posedge clk);
        #1;
        chk($sformatf("dut3_m_valid_%0h", d), 64'(tm_valid), 64'(exp_vld));
        @(negedge clk);
        t_valid = 1'b0;
    endtask

    // Monitor: every completed output handshake must match the queue head.
    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (m_valid[i] && m_ready[i]) begin
                    if (q[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_ch%0d: got beat %0h, expected none", i, m_data[i*8 +: 8]);
                    end else begin
                        logic [8:0] e;
                        e = q[i].pop_front();
                        chk($sformatf("beat_ch%0d", i), 64'({m_last[i], m_data[i*8 +: 8]}), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst_n    = 1'b0;
        s_data   = '0; s_sel = '0; s_last = 1'b0; s_valid = 1'b0;
        t_data   = '0; t_sel = '0; t_last = 1'b0; t_valid = 1'b0;
        m_ready  = 4'hF;
        tm_ready = 3'h7;
        #3;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last",  64'(m_last),  64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_dut3_m_valid", 64'(tm_valid), 64'd0);
`ifdef STREAM_DEMUX_ERRCNT_EN
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_s_ready", 64'(s_ready), 64'd1);
        @(negedge clk);

        // Single-beat packets, one per channel.
        for (int i = 0; i < 4; i++) begin
            send(8'(8'hA0 + i), 2'(i), 1'b1, i);
        end

        // Select changes mid-packet must be ignored.
        send(8'h21, 2'd2, 1'b0, 2);
        send(8'h22, 2'd1, 1'b0, 2);
        send(8'h23, 2'd1, 1'b1, 2);

        // Stalled channel: second beat held off until the consumer is ready.
        m_ready[1] = 1'b0;
        send(8'hB0, 2'd1, 1'b0, 1);
        s_data = 8'hB1; s_sel = 2'd1; s_last = 1'b1; s_valid = 1'b1;
        #1;
        chk("stall_s_ready_0", 64'(s_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("stall_s_ready_1", 64'(s_ready), 64'd0);
        chk("stall_hold_data", 64'(m_data[15:8]), 64'h00B0);
        @(negedge clk);
        m_ready[1] = 1'b1;
        send(8'hB1, 2'd1, 1'b1, 1);

        // ch0 stalls after its packet; ch1 must still take a beat per cycle.
        send(8'h60, 2'd0, 1'b0, 0);
        send(8'h61, 2'd0, 1'b1, 0);
        m_ready[0] = 1'b0;
        c0 = cyc;
        send(8'h70, 2'd1, 1'b0, 1);
        send(8'h71, 2'd1, 1'b0, 1);
        send(8'h72, 2'd1, 1'b1, 1);
        chk("ch1_cycles_for_3_beats", 64'(cyc - c0), 64'd3);
        chk("ch0_held_valid", 64'(m_valid[0]), 64'd1);
        chk("ch0_held_data",  64'(m_data[7:0]), 64'h61);
        m_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // 3-channel instance: select 3 is unused and must be dropped.
`ifdef STREAM_DEMUX_ERRCNT_EN
        chk("err_cnt_start", 64'(t_err_cnt), 64'd0);
`endif
        send3(8'h11, 2'd3, 1'b0, 3'b000);
        send3(8'h12, 2'd0, 1'b1, 3'b000);
`ifdef STREAM_DEMUX_ERRCNT_EN
        chk("err_cnt_one", 64'(t_err_cnt), 64'd1);
`endif
        send3(8'h33, 2'd2, 1'b1, 3'b100);
        chk("dut3_ch2_data", 64'(tm_data[23:16]), 64'h33);
        chk("dut3_ch2_last", 64'(tm_last[2]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            send3(8'(8'h40 + k), 2'd3, 1'b0, 3'b000);
            send3(8'(8'h50 + k), 2'd3, 1'b1, 3'b000);
        end
`ifdef STREAM_DEMUX_ERRCNT_EN
        chk("err_cnt_saturated", 64'(t_err_cnt), 64'd3);
`endif

        // Reset in the middle of a packet on ch0.
        send(8'hD0, 2'd0, 1'b0, 0);
        send(8'hD1, 2'd0, 1'b0, 0);
        s_data = 8'hD2; s_sel = 2'd0; s_last = 1'b1; s_valid = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk("midrst_m_data",  64'(m_data),  64'd0);
`ifdef STREAM_DEMUX_ERRCNT_EN
        chk("midrst_err_cnt", 64'(t_err_cnt), 64'd0);
`endif
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        send(8'hE3, 2'd3, 1'b1, 3);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drained_ch%0d", i), 64'(q[i].size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
